// File: rtl/fract_resamp_pkg.sv
// Shared constants for the fractional resampler: settings-bus offsets,
// CTRL register bit positions and the unity-ratio helper.
package fract_resamp_pkg;

  localparam logic [7:0] SR_RATIO_OFS = 8'd0;
  localparam logic [7:0] SR_CTRL_OFS  = 8'd1;

  localparam int CTRL_BYPASS = 0;
  localparam int CTRL_CLEAR  = 1;

  // 1.0 in a fixed-point format with phase_w fractional bits.
  function automatic int unsigned unity_ratio(input int unsigned phase_w);
    return 32'd1 << phase_w;
  endfunction

endpackage

// File: rtl/fract_resamp_lerp.sv
// One I or Q component of the interpolator: diff/multiply in the first stage,
// round-half-up, shift and saturate in the second. Both stages advance on i_en.
module fract_resamp_lerp #(
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 12
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_x_prev,
  input  logic signed [DATA_W-1:0] i_x_cur,
  input  logic [PHASE_W-1:0]       i_mu,
  output logic signed [DATA_W-1:0] o_y
);

  localparam int DIFF_W = DATA_W + 1;
  localparam int PROD_W = DATA_W + PHASE_W + 2;
  localparam int SUM_W  = DATA_W + PHASE_W + 3;
  localparam logic [SUM_W-1:0] HALF = SUM_W'(1) << (PHASE_W - 1);

  logic signed [DIFF_W-1:0]      w_diff;
  logic signed [PROD_W-1:0]      w_prod;
  logic signed [SUM_W-1:0]       w_base;
  logic signed [SUM_W-1:0]       w_sum;
  logic signed [SUM_W-1:0]       w_shift;
  logic [SUM_W-DATA_W:0]         w_hi;
  logic signed [DATA_W-1:0]      w_y;

  logic signed [PROD_W-1:0]      r_prod;
  logic signed [DATA_W-1:0]      r_x_prev;
  logic signed [DATA_W-1:0]      r_y;

  assign w_diff = {i_x_cur[DATA_W-1], i_x_cur} - {i_x_prev[DATA_W-1], i_x_prev};
  // mu is a pure fraction: a zero sign bit keeps it non-negative in the signed multiply.
  assign w_prod = $signed({1'b0, i_mu}) * w_diff;

  assign w_base  = {{(SUM_W-DATA_W-PHASE_W){r_x_prev[DATA_W-1]}}, r_x_prev, {PHASE_W{1'b0}}};
  assign w_sum   = w_base + {{(SUM_W-PROD_W){r_prod[PROD_W-1]}}, r_prod} + $signed(HALF);
  assign w_shift = w_sum >>> PHASE_W;
  assign w_hi    = w_shift[SUM_W-1:DATA_W-1];

  always_comb begin
    // NOTE: assign a default first so every path drives w_y and no latch is inferred.
    w_y = w_shift[DATA_W-1:0];
    if (!((&w_hi) || (~|w_hi))) begin
      w_y = w_shift[SUM_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

  // NOTE: datapath flops are reset as well so o_y (and hence m_tdata) reads 0 after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      r_prod   <= '0;
      r_x_prev <= '0;
      r_y      <= '0;
    end else if (i_en) begin
      r_prod   <= w_prod;
      r_x_prev <= i_x_prev;
      r_y      <= w_y;
    end
  end

  assign o_y = r_y;

endmodule

// File: rtl/fract_resampler_core.sv
// Multi-channel I/Q linear-interpolating fractional resampler with a phase accumulator.
// Optional status counters are built when FRACT_RESAMP_STATUS_EN is defined.
module fract_resampler_core
  import fract_resamp_pkg::*;
#(
  parameter int         DATA_W  = 16,
  parameter int         NUM_CH  = 1,
  parameter int         PHASE_W = 12,
  parameter int         INT_W   = 8,
  parameter logic [7:0] SR_BASE = 8'd128
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_set_stb,
  input  logic [7:0]                   i_set_addr,
  input  logic [31:0]                  i_set_data,
  input  logic [2*NUM_CH*DATA_W-1:0]   s_tdata,
  input  logic                         s_tvalid,
  input  logic                         s_tlast,
  output logic                         s_tready,
  output logic [2*NUM_CH*DATA_W-1:0]   m_tdata,
  output logic                         m_tvalid,
  output logic                         m_tlast,
  input  logic                         m_tready,
  output logic [31:0]                  o_in_cnt,
  output logic [31:0]                  o_out_cnt
);

  localparam int              RW         = INT_W + PHASE_W;
  localparam int              DW         = 2 * NUM_CH * DATA_W;
  localparam logic [RW-1:0]   UNITY      = RW'(unity_ratio(PHASE_W));
  localparam logic [7:0]      ADDR_RATIO = SR_BASE + SR_RATIO_OFS;
  localparam logic [7:0]      ADDR_CTRL  = SR_BASE + SR_CTRL_OFS;

  logic [RW-1:0]      r_ratio;
  logic [RW-1:0]      r_pos;
  logic               r_primed;
  logic               r_tlast_pend;
  logic               r_bypass;
  logic [DW-1:0]      r_x_prev;
  logic               r_v1;
  logic               r_last1;
  logic               r_v2;
  logic               r_last2;

  logic               w_en;
  logic               w_set_ratio;
  logic               w_set_ctrl;
  logic               w_clear;
  logic               w_accept;
  logic               w_take;
  logic               w_produce;
  logic               w_out_last;
  logic [RW-1:0]      w_ratio_req;
  logic [RW-1:0]      w_ratio_clamped;
  logic [RW-1:0]      w_pos_nxt;
  logic               w_primed_nxt;
  logic               w_pend_nxt;
  logic [DW-1:0]      w_x_prev_nxt;
  logic [DW-1:0]      w_lerp_prev;
  logic [PHASE_W-1:0] w_mu;
  logic [31:0]        w_unused_set_data;

  assign w_en     = !r_v2 || m_tready;
  assign s_tready = w_en;
  assign m_tvalid = r_v2;
  assign m_tlast  = r_last2;

  assign w_set_ratio     = i_set_stb && (i_set_addr == ADDR_RATIO);
  assign w_set_ctrl      = i_set_stb && (i_set_addr == ADDR_CTRL);
  assign w_clear         = w_set_ctrl && i_set_data[CTRL_CLEAR];
  assign w_ratio_req     = i_set_data[RW-1:0];
  assign w_ratio_clamped = (w_ratio_req < UNITY) ? UNITY : w_ratio_req;
  assign w_unused_set_data = i_set_data;

  // A clear that lands on a handshake drops the beat: it is accepted but never used.
  assign w_accept   = s_tvalid && w_en;
  assign w_take     = w_accept && !w_clear;
  assign w_produce  = w_take && (r_bypass || (r_primed && (r_pos < UNITY)));
  assign w_out_last = s_tlast || r_tlast_pend;

  // Bypass reuses the interpolator with x_prev = x_cur and mu = 0, which yields x_cur exactly.
  assign w_lerp_prev = r_bypass ? s_tdata : r_x_prev;
  assign w_mu        = r_bypass ? '0 : r_pos[PHASE_W-1:0];

  always_comb begin
    w_pos_nxt    = r_pos;
    w_primed_nxt = r_primed;
    w_pend_nxt   = r_tlast_pend;
    w_x_prev_nxt = r_x_prev;
    if (w_clear) begin
      w_pos_nxt    = '0;
      w_primed_nxt = 1'b0;
      w_pend_nxt   = 1'b0;
    end else if (w_take) begin
      if (r_bypass) begin
        w_pend_nxt = 1'b0;
      end else if (!r_primed) begin
        w_primed_nxt = 1'b1;
        w_x_prev_nxt = s_tdata;
        w_pend_nxt   = r_tlast_pend || s_tlast;
      end else begin
        w_x_prev_nxt = s_tdata;
        if (r_pos < UNITY) begin
          w_pos_nxt  = r_pos + r_ratio - UNITY;
          w_pend_nxt = 1'b0;
        end else begin
          w_pos_nxt  = r_pos - UNITY;
          w_pend_nxt = r_tlast_pend || s_tlast;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ratio      <= UNITY;
      r_pos        <= '0;
      r_primed     <= 1'b0;
      r_tlast_pend <= 1'b0;
      r_bypass     <= 1'b0;
      r_x_prev     <= '0;
      r_v1         <= 1'b0;
      r_last1      <= 1'b0;
      r_v2         <= 1'b0;
      r_last2      <= 1'b0;
    end else begin
      if (w_set_ratio) r_ratio <= w_ratio_clamped;
      if (w_set_ctrl)  r_bypass <= i_set_data[CTRL_BYPASS];
      r_pos        <= w_pos_nxt;
      r_primed     <= w_primed_nxt;
      r_tlast_pend <= w_pend_nxt;
      r_x_prev     <= w_x_prev_nxt;
      if (w_en) begin
        r_v1    <= w_produce;
        r_last1 <= w_produce && w_out_last;
        r_v2    <= r_v1;
        r_last2 <= r_v1 && r_last1;
      end
    end
  end

  for (genvar k = 0; k < 2 * NUM_CH; k++) begin : g_comp
    fract_resamp_lerp #(
      .DATA_W  (DATA_W),
      .PHASE_W (PHASE_W)
    ) u_lerp (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_en     (w_en),
      .i_x_prev (w_lerp_prev[k*DATA_W +: DATA_W]),
      .i_x_cur  (s_tdata[k*DATA_W +: DATA_W]),
      .i_mu     (w_mu),
      .o_y      (m_tdata[k*DATA_W +: DATA_W])
    );
  end

`ifdef FRACT_RESAMP_STATUS_EN
  logic [31:0] r_in_cnt;
  logic [31:0] r_out_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else if (w_clear) begin
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_accept)           r_in_cnt  <= r_in_cnt + 32'd1;
      if (r_v2 && m_tready)   r_out_cnt <= r_out_cnt + 32'd1;
    end
  end

  assign o_in_cnt  = r_in_cnt;
  assign o_out_cnt = r_out_cnt;
`else
  assign o_in_cnt  = '0;
  assign o_out_cnt = '0;
`endif

endmodule

// File: tb/tb_fract_resampler_core.sv
// Randomised bench for fract_resampler_core (NUM_CH=2) with a queue-based
// behavioural model, per-cycle output checks and literal anchors.
module tb_fract_resampler_core;

  localparam int W     = 16;
  localparam int NCH   = 2;
  localparam int P     = 12;
  localparam int IW    = 8;
  localparam int NC    = 2 * NCH;
  localparam int DW    = NC * W;
  localparam int UNITY = 1 << P;
  localparam logic [7:0] A_RATIO = 8'd128;
  localparam logic [7:0] A_CTRL  = 8'd129;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_set_stb;
  logic [7:0]    i_set_addr;
  logic [31:0]   i_set_data;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid, s_tlast, s_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid, m_tlast, m_tready;
  logic [31:0]   o_in_cnt, o_out_cnt;

  int n_vec = 0;
  int n_err = 0;
  int ready_mode = 0;

  // behavioural model state
  int            m_ratio, m_pos;
  bit            m_primed, m_pend, m_bypass;
  logic [DW-1:0] m_xprev;
  logic [31:0]   m_in_cnt, m_out_cnt;
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  logic [DW-1:0] got_d[$];
  bit            got_l[$];
  int            got_i[$];
  bit            was_stalled;
  logic [DW-1:0] held_d;
  logic          held_l;

  always #5 clk = ~clk;

  fract_resampler_core #(
    .DATA_W (W), .NUM_CH (NCH), .PHASE_W (P), .INT_W (IW), .SR_BASE (8'd128)
  ) dut (
    .i_clk (clk), .i_rst_n (rst_n),
    .i_set_stb (i_set_stb), .i_set_addr (i_set_addr), .i_set_data (i_set_data),
    .s_tdata (s_tdata), .s_tvalid (s_tvalid), .s_tlast (s_tlast), .s_tready (s_tready),
    .m_tdata (m_tdata), .m_tvalid (m_tvalid), .m_tlast (m_tlast), .m_tready (m_tready),
    .o_in_cnt (o_in_cnt), .o_out_cnt (o_out_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int comp(input logic [DW-1:0] d, input int k);
    logic signed [W-1:0] v;
    v = d[k*W +: W];
    return int'(v);
  endfunction

  // y = round_half_up(xp + mu/2^P * (xc - xp)), saturated to W bits
  function automatic logic [W-1:0] lerp_ref(input int xp, input int xc, input int mu);
    longint s;
    s = longint'(xp) * UNITY + longint'(mu) * longint'(xc - xp) + (UNITY / 2);
    s = s >>> P;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return W'(s);
  endfunction

  task automatic model_reset();
    m_ratio = UNITY; m_pos = 0; m_primed = 0; m_pend = 0; m_bypass = 0;
    m_xprev = '0; m_in_cnt = '0; m_out_cnt = '0;
    exp_d.delete(); exp_l.delete();
    was_stalled = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit clear_now;
      logic [DW-1:0] y;
      int r;
      check("s_tready", s_tready, !m_tvalid || m_tready);
`ifdef FRACT_RESAMP_STATUS_EN
      check("in_cnt", o_in_cnt, m_in_cnt);
      check("out_cnt", o_out_cnt, m_out_cnt);
`else
      check("in_cnt_tied", o_in_cnt, 0);
      check("out_cnt_tied", o_out_cnt, 0);
`endif
      if (was_stalled) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata, held_d);
        check("stall_last", m_tlast, held_l);
      end
      was_stalled = m_tvalid && !m_tready;
      held_d = m_tdata;
      held_l = m_tlast;
      if (m_tvalid && m_tready) begin
        m_out_cnt++;
        if (exp_d.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("m_tdata", m_tdata, exp_d.pop_front());
          check("m_tlast", m_tlast, exp_l.pop_front());
        end
        got_d.push_back(m_tdata);
        got_l.push_back(m_tlast);
        got_i.push_back(comp(m_tdata, 1));
      end
      clear_now = i_set_stb && (i_set_addr == A_CTRL) && i_set_data[1];
      if (s_tvalid && s_tready) begin
        m_in_cnt++;
        if (!clear_now) begin
          if (m_bypass) begin
            exp_d.push_back(s_tdata); exp_l.push_back(s_tlast || m_pend); m_pend = 0;
          end else if (!m_primed) begin
            m_xprev = s_tdata; m_primed = 1; m_pend = m_pend || s_tlast;
          end else begin
            if (m_pos < UNITY) begin
              for (int k = 0; k < NC; k++)
                y[k*W +: W] = lerp_ref(comp(m_xprev, k), comp(s_tdata, k), m_pos);
              exp_d.push_back(y); exp_l.push_back(s_tlast || m_pend);
              m_pend = 0;
              m_pos = m_pos + m_ratio - UNITY;
            end else begin
              m_pos = m_pos - UNITY;
              m_pend = m_pend || s_tlast;
            end
            m_xprev = s_tdata;
          end
        end
      end
      if (i_set_stb && i_set_addr == A_RATIO) begin
        r = int'(i_set_data & ((32'd1 << (IW + P)) - 1));
        m_ratio = (r < UNITY) ? UNITY : r;
      end
      if (i_set_stb && i_set_addr == A_CTRL) begin
        m_bypass = i_set_data[0];
        if (i_set_data[1]) begin
          m_pos = 0; m_primed = 0; m_pend = 0; m_in_cnt = '0; m_out_cnt = '0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = ($urandom_range(0, 99) < 40);
        default: m_tready = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] mk(input int ival, input bit extremes);
    logic [DW-1:0] d;
    for (int k = 0; k < NC; k++) begin
      d[k*W +: W] = W'($urandom);
      if (extremes) begin
        case ($urandom_range(0, 5))
          0: d[k*W +: W] = 16'h8000;
          1: d[k*W +: W] = 16'h7fff;
          default: ;
        endcase
      end
    end
    d[W +: W] = W'(ival);
    return d;
  endfunction

  task automatic set_write(input logic [7:0] addr, input logic [31:0] data);
    i_set_stb = 1'b1; i_set_addr = addr; i_set_data = data;
    @(posedge clk); #1;
    i_set_stb = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input bit last, input bit clr);
    int n = 0;
    s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
    if (clr) begin i_set_stb = 1'b1; i_set_addr = A_CTRL; i_set_data = 32'd2; end
    @(negedge clk);
    while (!s_tready && n < 1000) begin n++; @(negedge clk); end
    if (!s_tready) check("send_timeout", 0, 1);
    @(posedge clk); #1;
    s_tvalid = 1'b0; s_tlast = 1'b0; i_set_stb = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_d.size() != 0 && n < 2000) begin @(posedge clk); n++; end
    #1;
    check("drain", exp_d.size(), 0);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic restart();
    set_write(A_CTRL, 32'd2);
    got_d.delete(); got_l.delete(); got_i.delete();
  endtask

  task automatic check_list(input string name, input int e[$]);
    check({name, "_count"}, got_i.size(), e.size());
    for (int j = 0; j < e.size(); j++)
      check(name, (j < got_i.size()) ? got_i[j] : -99999, e[j]);
  endtask

  initial begin
    int eq[$];
    bit lq[$];
    logic [DW-1:0] sent[$];
    logic [DW-1:0] ref_d[$];
    logic [DW-1:0] beats[40];
    rst_n = 1'b0; i_set_stb = 0; i_set_addr = 0; i_set_data = 0;
    s_tdata = '0; s_tvalid = 0; s_tlast = 0; m_tready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", m_tvalid, 0);
    check("rst_m_tlast", m_tlast, 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_in_cnt", o_in_cnt, 0);
    check("rst_out_cnt", o_out_cnt, 0);
    rst_n = 1'b1;
    #1 check("rst_s_tready", s_tready, 1);
    @(posedge clk); #1;

    // unity ratio ramp, with an ignored write to an unmapped address mid-stream
    set_write(A_RATIO, 32'h1000);
    for (int i = 0; i < 8; i++) begin
      send_beat(mk(10 * i, 0), 0, 0);
      if (i == 3) set_write(8'd130, 32'd3);
    end
    drain();
    eq = {}; for (int j = 0; j < 7; j++) eq.push_back(10 * j);
    check_list("t1_unity", eq);
    restart();

    // ratio below 1.0 (upper data bits ignored) is clamped to 1.0
    set_write(A_RATIO, 32'hABC0_0800);
    for (int i = 0; i < 5; i++) send_beat(mk(7 * i, 1), 0, 0);
    drain();
    check_list("t1_clamp", {0, 7, 14, 21});
    restart();

    set_write(A_RATIO, 32'h1800);
    for (int i = 0; i < 6; i++) send_beat(mk(100 * i, 0), 0, 0);
    drain();
    check_list("t2_r1p5", {0, 150, 300, 450});
    restart();

    for (int i = 0; i < 3; i++) send_beat(mk(i, 0), 0, 0);
    drain();
    check_list("t3_round", {0, 2});
    restart();

    set_write(A_RATIO, 32'h2000);
    for (int i = 0; i < 8; i++) send_beat(mk(100 * i, 0), (i == 4), 0);
    drain();
    check_list("t4_r2", {0, 200, 400, 600});
    lq = {0, 0, 1, 0};
    for (int j = 0; j < 4; j++) check("t4_last", (j < got_l.size()) ? got_l[j] : 1'bx, lq[j]);
    restart();

    // clear colliding with a handshake drops that beat and re-primes
    set_write(A_RATIO, 32'h1000);
    send_beat(mk(5, 0), 0, 0);
    send_beat(mk(6, 0), 0, 0);
    send_beat(mk(7, 0), 0, 1);
    send_beat(mk(8, 0), 0, 0);
    send_beat(mk(9, 0), 0, 0);
    drain();
    check_list("t_clear", {5, 8});
    restart();

    // bypass: every beat passes through unchanged
    set_write(A_CTRL, 32'd1);
    sent.delete(); lq = {};
    for (int i = 0; i < 6; i++) begin
      sent.push_back(mk($urandom_range(0, 999), 1));
      lq.push_back(bit'($urandom_range(0, 1)));
      send_beat(sent[i], lq[i], 0);
    end
    drain();
    check("byp_count", got_d.size(), 6);
    for (int j = 0; j < 6 && j < got_d.size(); j++) begin
      check("byp_data", got_d[j], sent[j]);
      check("byp_last", got_l[j], lq[j]);
    end
    restart();

    // ratio change mid-stream, random data and random tlast
    set_write(A_RATIO, 32'h1400);
    for (int i = 0; i < 24; i++) begin
      send_beat(mk($urandom_range(0, 4000), 1), ($urandom_range(0, 5) == 0), 0);
      if (i == 11) set_write(A_RATIO, 32'h1C00);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    restart();

    // same stream with and without backpressure must match
    set_write(A_RATIO, 32'h1400);
    for (int i = 0; i < 40; i++) beats[i] = mk($urandom_range(0, 30000), 1);
    for (int i = 0; i < 40; i++) send_beat(beats[i], 0, 0);
    drain();
    ref_d = got_d;
    restart();
    ready_mode = 1;
    for (int i = 0; i < 40; i++) send_beat(beats[i], 0, 0);
    drain();
    ready_mode = 0;
    check("bp_count", got_d.size(), ref_d.size());
    for (int j = 0; j < ref_d.size() && j < got_d.size(); j++)
      check("bp_stream", got_d[j], ref_d[j]);
    restart();

    // async reset with an output held by backpressure
    ready_mode = 2;
    set_write(A_RATIO, 32'h1000);
    send_beat(mk(40, 0), 0, 0);
    send_beat(mk(50, 0), 0, 0);
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_valid", m_tvalid, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_m_tvalid", m_tvalid, 0);
    check("arst_m_tdata", m_tdata, 0);
    check("arst_in_cnt", o_in_cnt, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    ready_mode = 0;
    got_d.delete(); got_l.delete(); got_i.delete();
    #1;
    check("post_rst_s_tready", s_tready, 1);
    check("post_rst_in_cnt", o_in_cnt, 0);
    check("post_rst_out_cnt", o_out_cnt, 0);
    @(posedge clk); #1;
    send_beat(mk(111, 0), 0, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("prime_no_output", got_i.size(), 0);
    send_beat(mk(222, 0), 0, 0);
    send_beat(mk(333, 0), 0, 0);
    drain();
    check_list("post_rst", {111, 222});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fract_resampler_core.md
Name: fract_resampler_core

Overview:
- Parametrised successor to the fixed 16-bit single-channel fractional decimator.
- Resamples NUM_CH complex (I/Q) channels, carried together in one AXI-stream beat, by a runtime ratio R in [1.0, 2^INT_W), using linear interpolation driven by a phase accumulator.
- Sits between the AXI wrapper's m_axis/s_axis data ports inside a NoC block and is configured through the settings bus.

Parameters:
- DATA_W, 16: bits per I or Q component (signed).
- NUM_CH, 1: complex channels per beat.
- PHASE_W, 12: fractional bits of ratio and accumulator.
- INT_W, 8: integer bits of ratio.
- SR_BASE, 8'd128: base settings-bus address.

Ports:
- i_clk  in  1  single clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_set_stb  in  1  settings write strobe.
- i_set_addr  in  8  settings address.
- i_set_data  in  32  settings data.
- s_tdata  in  2*NUM_CH*DATA_W  input samples; channel c occupies I=[c*2W+2W-1 : c*2W+W], Q=[c*2W+W-1 : c*2W].
- s_tvalid  in  1  input valid.
- s_tlast  in  1  input end of packet.
- s_tready  out  1  input ready.
- m_tdata  out  2*NUM_CH*DATA_W  output samples, same packing as s_tdata.
- m_tvalid  out  1  output valid.
- m_tlast  out  1  output end of packet.
- m_tready  in  1  output ready.
- o_in_cnt  out  32  accepted-input count (see optional feature).
- o_out_cnt  out  32  produced-output count (see optional feature).

Behaviour:
- Reset values:
  - m_tvalid=0, m_tlast=0, m_tdata=0, counters=0.
  - ratio=1.0 (1<<PHASE_W), pos=0, primed=0, tlast_pend=0.
  - s_tready=1 on the first cycle after reset release.
- Registers:
  - SR_BASE+0 RATIO: unsigned Q(INT_W.PHASE_W) taken from i_set_data[INT_W+PHASE_W-1:0]. Values below 1.0 are clamped to 1.0 on write.
  - SR_BASE+1 CTRL: bit0 = bypass (level); bit1 = clear (self-clearing pulse).
  - Other addresses are ignored.
- Handshake:
  - 2-stage pipeline with valid bits v1, v2 (v2 == m_tvalid); en = !v2 | m_tready; s_tready = en.
  - Every accepted input updates state. Only producing inputs set v1.
  - At most one output per input.
  - m_tdata/m_tlast are held stable while m_tvalid=1 and m_tready=0.
- Algorithm:
  - pos is the next output position relative to x_prev, in Q(INT_W.PHASE_W).
  - If primed=0, the first accepted beat loads x_prev, sets primed=1 and produces no output.
  - On each later accepted beat x_cur:
    - if pos<1.0: emit y = x_prev + mu*(x_cur-x_prev) with mu = pos[PHASE_W-1:0], then set pos = pos + ratio - 1.0;
    - otherwise set pos = pos - 1.0 and emit nothing.
  - In both cases x_prev <= x_cur.
- Arithmetic, per component:
  - diff is DATA_W+1 bits signed; mu is unsigned, zero-extended.
  - sum = (x_prev<<PHASE_W) + mu*diff + (1<<(PHASE_W-1)), rounding half-up.
  - y = sum >>> PHASE_W, saturated to DATA_W.
- Latency: 2 cycles from a producing input handshake to m_tvalid, absent backpressure.
- tlast:
  - A producing beat with s_tlast=1 gives m_tlast=1 on its output.
  - A non-producing beat with s_tlast=1 sets tlast_pend; the next output carries m_tlast=1 and clears tlast_pend.
- Bypass: every accepted beat produces output y = x_cur, with pos and primed untouched. Same latency.
- Ratio write mid-stream: the new ratio is used at the next pos update, with no pipeline flush.
- Clear: resets pos, primed and tlast_pend in the same cycle. Data already in v1/v2 still drains. If clear coincides with an input handshake, clear wins and the beat is dropped.
- Async reset mid-operation: all state, including in-flight outputs, is discarded immediately.

Optional Feature:
- Macro: FRACT_RESAMP_STATUS_EN.
- When defined:
  - o_in_cnt increments on each s_tvalid&s_tready.
  - o_out_cnt increments on each m_tvalid&m_tready.
  - Both are 32-bit, wrap at 2^32, and are cleared by CTRL.clear and by reset.
- When undefined: both ports are tied to 0 and no counter flops are generated. The port list is unchanged.

Decomposition:
- Package fract_resamp_pkg holds:
  - SR offsets (SR_RATIO_OFS=0, SR_CTRL_OFS=1);
  - CTRL bit indices (CTRL_BYPASS=0, CTRL_CLEAR=1);
  - function for the unity-ratio constant.
- Sub-module fract_resamp_lerp: one component's diff/multiply/round/saturate datapath, pipelined to match v1/v2. Instantiated 2*NUM_CH times via generate.

Test Plan:
- Ratio 0x1000 (1.0, PHASE_W=12), I ramp 0,10,20,... -> outputs 0,10,20,... (one-sample delay), one output per input after the priming beat.
- Ratio 0x1800 (1.5), I ramp 0,100,200,300,400,500 -> outputs 0,150,300,450.
- Ratio 0x1800 with inputs 0,1,2 -> second output rounds 0.5*1 + 1 = 1.5 up to 2 (first output 0).
- Ratio 0x2000 (2.0), 8 beats with s_tlast on beat 4 (non-producing) -> 4 outputs (x0,x2,x4,x6), m_tlast on the output holding x4.
- Random m_tready (~40% duty), NUM_CH=2, ratio 0x1400 -> output stream identical to the no-backpressure run, no drops or duplicates, m_tdata stable while stalled.
- i_rst_n pulled low with v2 set and m_tready=0 -> m_tvalid=0 immediately; after release, the first beat primes (no output), and counters read 0 when FRACT_RESAMP_STATUS_EN is defined.
